ras_spec_stage: RTL and testbench

RAS_SPEC_STAGE -- requirements
Module: ras_spec_stage

---
 rtl/ras_pkg.sv | 17 +
 rtl/ras_bram.sv | 33 +++
 rtl/ras_spec_fifo.sv | 45 ++++
 rtl/ras_spec_stage.sv | 133 +++++++++++++
 tb/tb_ras_spec_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// Shared return-address-stack types and default sizing.
package ras_pkg;

    localparam int unsigned RAS_WIDTH    = 32;
    localparam int unsigned RAS_DEPTH    = 1024;
    localparam int unsigned RAS_SP_DEPTH = 16;
    localparam int unsigned RAS_AW       = $clog2(RAS_DEPTH);

    // One speculative stack action as queued for retirement.
    typedef struct packed {
        logic [RAS_WIDTH-1:0] data;
        logic [RAS_AW-1:0]    addr;
        logic                 pop;
        logic                 push;
    } ras_action_t;

endpackage

// File: rtl/ras_bram.sv
// Simple dual-port RAM: port A synchronous read, port B write.
// With RESOLVE_COLLIDE set, a same-cycle write to the read index is forwarded.
module ras_bram #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEPTH           = 16,
    parameter bit          RESOLVE_COLLIDE = 1'b1,
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_a_addr,
    output logic [WIDTH-1:0] o_a_dout,
    input  logic             i_b_we,
    input  logic [AW-1:0]    i_b_addr,
    input  logic [WIDTH-1:0] i_b_din
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_a_dout;

    // Port B write; the array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_b_we) r_mem[i_b_addr] <= i_b_din;
    end

    // Port A registered read with optional write-first forwarding.
    always_ff @(posedge clk) begin
        if (RESOLVE_COLLIDE && i_b_we && (i_b_addr == i_a_addr)) r_a_dout <= i_b_din;
        else                                                     r_a_dout <= r_mem[i_a_addr];
    end

    assign o_a_dout = r_a_dout;

endmodule

// File: rtl/ras_spec_fifo.sv
// Show-ahead FIFO with synchronous flush and occupancy count.
// The caller never pushes when full nor pops when empty.
module ras_spec_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [DW-1:0] o_dout,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Entry storage, no reset needed: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers and count; flush discards everything, including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ras_spec_stage.sv
// Speculative RAS front stage: queues actions until retired, keeps a small
// scratchpad of speculatively pushed addresses, and tracks visible/masked
// entry counts plus speculative and committed stack pointers.
module ras_spec_stage
    import ras_pkg::*;
#(
    parameter int unsigned WIDTH    = RAS_WIDTH,
    parameter int unsigned DEPTH    = RAS_DEPTH,
    parameter int unsigned SP_DEPTH = RAS_SP_DEPTH,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(SP_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    output logic             ready_o,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             commit,
    input  logic             flush,
    output logic             cvalid_o,
    output logic             push_o,
    output logic             pop_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AW-1:0]    addr_o,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [AW-1:0]    base_addr,
    output logic [AW-1:0]    commit_addr_o,
    output logic [CW-1:0]    pend_cnt_o
);

    localparam int unsigned SW       = $clog2(SP_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(SP_DEPTH);

    logic                      w_accept;
    logic                      w_push_acc;
    logic                      w_pop_acc;
    ras_action_t               w_in_act;
    ras_action_t               w_head;
    logic [$bits(ras_action_t)-1:0] w_fifo_dout;
    logic [CW-1:0]             r_v, r_m, w_v_d, w_m_d;
    logic [AW-1:0]             r_spec_ptr, r_commit_addr, w_commit_addr_d;

    // Reset and flush both override a new action.
    assign ready_o    = (pend_cnt_o != FULL_CNT);
    assign w_accept   = trigger && ready_o && !flush && !reset;
    assign w_push_acc = w_accept && push_i;
    assign w_pop_acc  = w_accept && pop_i;
    assign cvalid_o   = commit && !reset && (pend_cnt_o != '0);

    assign w_in_act = '{data: data_i, addr: addr_i, pop: pop_i, push: push_i};
    assign w_head   = w_fifo_dout;

    ras_spec_fifo #(
        .DW    ($bits(ras_action_t)),
        .DEPTH (SP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_din   (w_in_act),
        .i_pop   (cvalid_o),
        .i_flush (flush),
        .o_dout  (w_fifo_dout),
        .o_count (pend_cnt_o)
    );

    ras_bram #(
        .WIDTH           (WIDTH),
        .DEPTH           (SP_DEPTH),
        .RESOLVE_COLLIDE (1'b1)
    ) u_scratch (
        .clk      (clk),
        .i_a_addr (addr[SW-1:0]),
        .o_a_dout (dout),
        .i_b_we   (w_push_acc),
        .i_b_addr (addr_i[SW-1:0]),
        .i_b_din  (data_i)
    );

    assign push_o = w_head.push;
    assign pop_o  = w_head.pop;
    assign data_o = w_head.data;
    assign addr_o = w_head.addr;

    assign valid           = (r_v != '0);
    assign base_addr       = w_accept ? addr_i : r_spec_ptr;
    assign commit_addr_o   = r_commit_addr;
    assign w_commit_addr_d = cvalid_o ? w_head.addr : r_commit_addr;

    // Visible/masked counters: a speculative pop hides a visible entry; retiring
    // a push first consumes a mask, otherwise it retires a visible entry.
    always_comb begin
        w_v_d = r_v;
        w_m_d = r_m;
        if (w_push_acc && (w_v_d != FULL_CNT)) w_v_d = w_v_d + CW'(1);
        if (w_pop_acc && (r_v != '0)) begin
            w_v_d = w_v_d - CW'(1);
            if (w_m_d != FULL_CNT) w_m_d = w_m_d + CW'(1);
        end
        if (cvalid_o && w_head.push) begin
            if (r_m == '0) begin
                if (w_v_d != '0) w_v_d = w_v_d - CW'(1);
            end else begin
                w_m_d = w_m_d - CW'(1);
            end
        end
        if (flush) begin
            w_v_d = '0;
            w_m_d = '0;
        end
    end

    // State update; flush rewinds the speculative pointer to the post-commit pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v           <= '0;
            r_m           <= '0;
            r_spec_ptr    <= addr;
            r_commit_addr <= addr;
        end else begin
            r_v           <= w_v_d;
            r_m           <= w_m_d;
            r_commit_addr <= w_commit_addr_d;
            r_spec_ptr    <= flush ? w_commit_addr_d : base_addr;
        end
    end

endmodule

// File: tb/tb_ras_spec_stage.sv
// Directed-vector bench for ras_spec_stage with default parameters.
module tb_ras_spec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger, push_i, pop_i, commit, flush;
    logic [31:0] data_i;
    logic [9:0]  addr_i, addr;
    logic        ready_o, cvalid_o, push_o, pop_o, valid;
    logic [31:0] data_o, dout;
    logic [9:0]  addr_o, base_addr, commit_addr_o;
    logic [4:0]  pend_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ras_spec_stage dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .ready_o       (ready_o),
        .push_i        (push_i),
        .pop_i         (pop_i),
        .data_i        (data_i),
        .addr_i        (addr_i),
        .commit        (commit),
        .flush         (flush),
        .cvalid_o      (cvalid_o),
        .push_o        (push_o),
        .pop_o         (pop_o),
        .data_o        (data_o),
        .addr_o        (addr_o),
        .addr          (addr),
        .dout          (dout),
        .valid         (valid),
        .base_addr     (base_addr),
        .commit_addr_o (commit_addr_o),
        .pend_cnt_o    (pend_cnt_o)
    );

    typedef struct {
        string       name;
        logic        rst, trig, push, pop;
        logic [31:0] data;
        logic [9:0]  waddr;
        logic        cmt, fl;
        logic [9:0]  raddr;
        logic        e_cv, e_hpush, e_hpop, e_rdy;
        logic [4:0]  e_pend;
        logic        e_valid;
        logic [9:0]  e_base, e_caddr;
        logic        chk_dout;
        logic [31:0] e_dout;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst, trig, push, pop,
                       input logic [31:0] data, input logic [9:0] waddr,
                       input logic cmt, fl, input logic [9:0] raddr,
                       input logic e_cv, e_hpush, e_hpop, e_rdy,
                       input logic [4:0] e_pend, input logic e_valid,
                       input logic [9:0] e_base, e_caddr,
                       input logic chk_dout, input logic [31:0] e_dout);
        vec_t v;
        v = '{name, rst, trig, push, pop, data, waddr, cmt, fl, raddr,
              e_cv, e_hpush, e_hpop, e_rdy, e_pend, e_valid, e_base, e_caddr, chk_dout, e_dout};
        vq.push_back(v);
    endtask

    task automatic idle();
        reset = 1'b0; trigger = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        commit = 1'b0; flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        reset = v.rst; trigger = v.trig; push_i = v.push; pop_i = v.pop;
        data_i = v.data; addr_i = v.waddr; commit = v.cmt; flush = v.fl; addr = v.raddr;
        #1;
        chk({v.name, "/cvalid"}, 32'(cvalid_o), 32'(v.e_cv));
        chk({v.name, "/ready"}, 32'(ready_o), 32'(v.e_rdy));
        if (v.e_cv) begin
            chk({v.name, "/head_push"}, 32'(push_o), 32'(v.e_hpush));
            chk({v.name, "/head_pop"}, 32'(pop_o), 32'(v.e_hpop));
        end
        @(posedge clk);
        #1;
        idle();
        #1;
        chk({v.name, "/pend"}, 32'(pend_cnt_o), 32'(v.e_pend));
        chk({v.name, "/valid"}, 32'(valid), 32'(v.e_valid));
        chk({v.name, "/base"}, 32'(base_addr), 32'(v.e_base));
        chk({v.name, "/caddr"}, 32'(commit_addr_o), 32'(v.e_caddr));
        if (v.chk_dout) chk({v.name, "/dout"}, dout, v.e_dout);
    endtask

    initial begin
        //   name         rst trg psh pop data  wa  cmt fl  ra    cv hp hpp rdy pend vld base cad  cd dout
        add("rst0",       1, 0, 0, 0, 32'h0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 1, 5'd0, 0, 10'd0, 10'd0, 0, 32'h0);
        // three pushes, read index 2, then a write-first collision
        add("pushA",      0, 1, 1, 0, 32'hA, 10'd1, 0, 0, 10'd0, 0, 0, 0, 1, 5'd1, 1, 10'd1, 10'd0, 0, 32'h0);
        add("pushB",      0, 1, 1, 0, 32'hB, 10'd2, 0, 0, 10'd0, 0, 0, 0, 1, 5'd2, 1, 10'd2, 10'd0, 0, 32'h0);
        add("pushC_rd2",  0, 1, 1, 0, 32'hC, 10'd3, 0, 0, 10'd2, 0, 0, 0, 1, 5'd3, 1, 10'd3, 10'd0, 1, 32'hB);
        add("fwd",        0, 1, 1, 0, 32'hD, 10'd2, 0, 0, 10'd2, 0, 0, 0, 1, 5'd4, 1, 10'd2, 10'd0, 1, 32'hD);
        // push then masking pop, retire both
        add("rst1",       1, 0, 0, 0, 32'h0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 1, 5'd0, 0, 10'd0, 10'd0, 0, 32'h0);
        add("pushA1",     0, 1, 1, 0, 32'hA, 10'd1, 0, 0, 10'd0, 0, 0, 0, 1, 5'd1, 1, 10'd1, 10'd0, 0, 32'h0);
        add("pop0",       0, 1, 0, 1, 32'h0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 1, 5'd2, 0, 10'd0, 10'd0, 0, 32'h0);
        add("cmt_push",   0, 0, 0, 0, 32'h0, 10'd0, 1, 0, 10'd0, 1, 1, 0, 1, 5'd1, 0, 10'd0, 10'd1, 0, 32'h0);
        add("cmt_pop",    0, 0, 0, 0, 32'h0, 10'd0, 1, 0, 10'd0, 1, 0, 1, 1, 5'd0, 0, 10'd0, 10'd0, 0, 32'h0);
        add("cmt_empty",  0, 0, 0, 0, 32'h0, 10'd0, 1, 0, 10'd0, 0, 0, 0, 1, 5'd0, 0, 10'd0, 10'd0, 0, 32'h0);
        add("pushE",      0, 1, 1, 0, 32'hE, 10'd1, 0, 0, 10'd0, 0, 0, 0, 1, 5'd1, 1, 10'd1, 10'd0, 0, 32'h0);
        add("cmt_unmask", 0, 0, 0, 0, 32'h0, 10'd0, 1, 0, 10'd0, 1, 1, 0, 1, 5'd0, 0, 10'd1, 10'd1, 0, 32'h0);
        // commit one of three, then flush
        add("rst2",       1, 0, 0, 0, 32'h0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 1, 5'd0, 0, 10'd0, 10'd0, 0, 32'h0);
        add("push5",      0, 1, 1, 0, 32'h5, 10'd5, 0, 0, 10'd0, 0, 0, 0, 1, 5'd1, 1, 10'd5, 10'd0, 0, 32'h0);
        add("push6",      0, 1, 1, 0, 32'h6, 10'd6, 0, 0, 10'd0, 0, 0, 0, 1, 5'd2, 1, 10'd6, 10'd0, 0, 32'h0);
        add("push7",      0, 1, 1, 0, 32'h7, 10'd7, 0, 0, 10'd0, 0, 0, 0, 1, 5'd3, 1, 10'd7, 10'd0, 0, 32'h0);
        add("cmt5",       0, 0, 0, 0, 32'h0, 10'd0, 1, 0, 10'd0, 1, 1, 0, 1, 5'd2, 1, 10'd7, 10'd5, 0, 32'h0);
        add("flush",      0, 0, 0, 0, 32'h0, 10'd0, 0, 1, 10'd0, 0, 0, 0, 1, 5'd0, 0, 10'd5, 10'd5, 0, 32'h0);
        // commit + flush + trigger together; dropped push must not reach index 1
        add("push8",      0, 1, 1, 0, 32'h11, 10'd8, 0, 0, 10'd0, 0, 0, 0, 1, 5'd1, 1, 10'd8, 10'd5, 0, 32'h0);
        add("push9",      0, 1, 1, 0, 32'h22, 10'd9, 0, 0, 10'd0, 0, 0, 0, 1, 5'd2, 1, 10'd9, 10'd5, 0, 32'h0);
        add("cmt_fl_trg", 0, 1, 1, 0, 32'h33, 10'd1, 1, 1, 10'd1, 1, 1, 0, 1, 5'd0, 0, 10'd8, 10'd8, 1, 32'hE);
        // five pending, then reset with trigger and commit asserted
        for (int i = 0; i < 5; i++) begin
            add($sformatf("fill5_%0d", i), 0, 1, 1, 0, 32'h20 + 32'(i), 10'(20 + i), 0, 0, 10'd0,
                0, 0, 0, 1, 5'(i + 1), 1, 10'(20 + i), 10'd8, 0, 32'h0);
        end
        add("rst_mid",    1, 1, 1, 0, 32'h99, 10'd3, 1, 0, 10'd3, 0, 0, 0, 1, 5'd0, 0, 10'd3, 10'd3, 1, 32'hC);

        idle();
        reset = 1'b1; data_i = '0; addr_i = '0; addr = '0;
        repeat (2) @(posedge clk);
        #2;
        foreach (vq[i]) run_vec(vq[i]);

        // Fill to capacity, drop the 17th, then retire one
        for (int i = 0; i < 16; i++) begin
            trigger = 1'b1; push_i = 1'b1; data_i = 32'h100 + 32'(i); addr_i = 10'(i);
            @(posedge clk);
            #1;
            idle();
            #1;
        end
        chk("full/pend", 32'(pend_cnt_o), 32'd16);
        chk("full/ready", 32'(ready_o), 32'd0);
        trigger = 1'b1; push_i = 1'b1; data_i = 32'h1FF; addr_i = 10'd9;
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("drop17/pend", 32'(pend_cnt_o), 32'd16);
        commit = 1'b1;
        #1;
        chk("full_cmt/cvalid", 32'(cvalid_o), 32'd1);
        chk("full_cmt/head", data_o, 32'h100);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("full_cmt/pend", 32'(pend_cnt_o), 32'd15);
        chk("full_cmt/ready", 32'(ready_o), 32'd1);
        // Trigger and commit together: net occupancy unchanged
        trigger = 1'b1; push_i = 1'b1; data_i = 32'h200; addr_i = 10'd2; commit = 1'b1;
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("trg_cmt/pend", 32'(pend_cnt_o), 32'd15);
        chk("trg_cmt/head", data_o, 32'h102);
        chk("trg_cmt/ready", 32'(ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
